// File: rtl/kbd_spi_rx.sv
// SPI slave receiver for the keyboard/joystick link: 40-key matrix plus Kempston byte.
// Define KBD_JOY_EN for the 48-bit frame carrying JOY; otherwise frames are 40 bits and JOY reads 0.
module kbd_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 4
) (
  input  logic                 CLK_14MHZ,
  input  logic                 RESET,
  input  logic                 KBD_CLK,
  input  logic                 KBD_CS,
  input  logic                 KBD_DI,
  input  logic [7:0]           A_HI,
  output logic [4:0]           KD,
  output logic [7:0]           JOY,
  output logic                 FRAME_STB,
  output logic                 FRAME_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

`ifdef KBD_JOY_EN
  localparam int FRAME_BITS = 48;
`else
  localparam int FRAME_BITS = 40;
`endif
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                  state;
  logic [SYNC_STAGES:0]    sck_sync;
  logic [SYNC_STAGES:0]    cs_sync;
  logic [SYNC_STAGES-1:0]  di_sync;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    overflow;
  logic                    restart;
  logic [FRAME_BITS-1:0]   sr;
  logic [39:0]             matrix;
  logic                    sck_rise;
  logic                    cs_rise;
  logic                    cs_fall;
  logic                    di_bit;
  logic                    shift_en;

  // CS chain resets low so a CS held low across reset release never looks like a falling edge
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) begin
      sck_sync <= '0;
      cs_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-1:0], KBD_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-1:0], KBD_CS};
    end
  end

  always_ff @(posedge CLK_14MHZ) begin
    di_sync <= {di_sync[SYNC_STAGES-2:0], KBD_DI};
  end

  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_sync[SYNC_STAGES];
  assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
  assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];
  assign di_bit   = di_sync[SYNC_STAGES-1];
  assign shift_en = (state == SHIFT) && sck_rise && !cs_rise && (bit_cnt != FRAME_CNT);

  always_ff @(posedge CLK_14MHZ) begin
    if (shift_en) sr <= {sr[FRAME_BITS-2:0], di_bit};
  end

`ifdef KBD_JOY_EN
  logic [7:0] joy_r;

  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) joy_r <= 8'h00;
    else if (state == CHECK && bit_cnt == FRAME_CNT && !overflow) joy_r <= sr[47:40];
  end

  assign JOY = joy_r;
`else
  assign JOY = 8'h00;
`endif

  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      overflow  <= 1'b0;
      restart   <= 1'b0;
      matrix    <= '1;
      FRAME_STB <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      FRAME_STB <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          restart <= 1'b0;
          // restart covers a CS falling edge that landed while we were in CHECK
          if (cs_fall || (restart && !cs_sync[SYNC_STAGES])) begin
            bit_cnt  <= '0;
            overflow <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= CHECK;
          end else if (sck_rise) begin
            if (bit_cnt == FRAME_CNT) overflow <= 1'b1;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          restart <= cs_fall;
          if (bit_cnt == FRAME_CNT && !overflow) begin
            matrix    <= sr[39:0];
            FRAME_STB <= 1'b1;
          end else begin
            FRAME_ERR <= 1'b1;
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    KD = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!A_HI[r]) KD = KD & matrix[5*r +: 5];
    end
  end

endmodule

// File: tb/tb_kbd_spi_rx.sv
// Randomised scoreboard bench for kbd_spi_rx; frames bit-banged over the SPI pins.
module tb_kbd_spi_rx;
  localparam int SYNC = 2;
  localparam int EW   = 4;
`ifdef KBD_JOY_EN
  localparam int  FB     = 48;
  localparam bit  JOY_ON = 1'b1;
`else
  localparam int  FB     = 40;
  localparam bit  JOY_ON = 1'b0;
`endif
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b0;
  logic          cs  = 1'b1;
  logic          di  = 1'b0;
  logic [7:0]    a_hi = 8'hFF;
  logic [4:0]    kd;
  logic [7:0]    joy;
  logic          stb;
  logic          ferr;
  logic [EW-1:0] err_cnt;

  kbd_spi_rx #(.SYNC_STAGES(SYNC), .ERR_CNT_W(EW)) dut (
    .CLK_14MHZ(clk), .RESET(rst), .KBD_CLK(sck), .KBD_CS(cs), .KBD_DI(di),
    .A_HI(a_hi), .KD(kd), .JOY(joy), .FRAME_STB(stb), .FRAME_ERR(ferr), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          err;
    logic [39:0] rows;
    logic [7:0]  joy;
    logic [EW-1:0] ecnt;
    int          rise;
  } exp_t;
  exp_t q[$];

  // reference state: what the keyboard should currently show
  logic [4:0] m_rows [8];
  logic [7:0] m_joy;
  int         m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [39:0] pack_rows(input logic [4:0] rows [8]);
    logic [39:0] v;
    for (int r = 0; r < 8; r++) v[5*r +: 5] = rows[r];
    return v;
  endfunction

  // a key column reads pressed if any selected half-row has that key down
  function automatic logic [4:0] model_kd(input logic [7:0] a, input logic [39:0] rv);
    logic [4:0] k;
    for (int c = 0; c < 5; c++) begin
      k[c] = 1'b1;
      for (int r = 0; r < 8; r++)
        if (a[r] == 1'b0 && rv[5*r + c] == 1'b0) k[c] = 1'b0;
    end
    return k;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input bit v);
    di = v;
    tick(3);
    sck = 1'b1;
    tick(3);
    sck = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_rows[r] = 5'h1F;
    m_joy = 8'h00;
    m_err = 0;
    q.delete();
  endtask

  task automatic send_frame(input logic [7:0] fj, input logic [4:0] rows [8], input int n, input int gap);
    bit   b[$];
    exp_t e;
    if (JOY_ON) for (int k = 7; k >= 0; k--) b.push_back(fj[k]);
    for (int r = 7; r >= 0; r--)
      for (int k = 4; k >= 0; k--) b.push_back(rows[r][k]);
    while (b.size() > n) void'(b.pop_back());
    while (b.size() < n) b.push_back(1'($urandom_range(0, 1)));
    cs = 1'b0;
    foreach (b[i]) clock_bit(b[i]);
    tick(3);
    cs = 1'b1;
    if (n == FB) begin
      for (int r = 0; r < 8; r++) m_rows[r] = rows[r];
      m_joy = JOY_ON ? fj : 8'h00;
      e.err = 1'b0;
    end else begin
      if (m_err < ERR_MAX) m_err++;
      e.err = 1'b1;
    end
    e.rows = pack_rows(m_rows);
    e.joy  = m_joy;
    e.ecnt = EW'(m_err);
    e.rise = cyc;
    q.push_back(e);
    tick(gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    tick(2);
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic rand_rows(output logic [4:0] rows [8]);
    for (int r = 0; r < 8; r++) rows[r] = 5'($urandom_range(0, 31));
  endtask

  // monitor: pops one expectation per strobe
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && (stb || ferr)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe stb=%0b err=%0b required=none", stb, ferr);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {62'd0, stb, ferr}, e.err ? 64'd1 : 64'd2);
        chk("err_cnt", 64'(err_cnt), 64'(e.ecnt));
        chk("joy", 64'(joy), 64'(e.joy));
        chk("kd", 64'(kd), 64'(model_kd(a_hi, e.rows)));
        chk("strobe_latency_ok", 64'((cyc - e.rise) >= 1 && (cyc - e.rise) <= SYNC + 2), 64'd1);
      end
    end
  end

  initial begin
    logic [4:0] rows [8];
    int n;
    int seen;
    model_reset();

    // reset state
    tick(3);
    chk("reset_kd", 64'(kd), 64'h1F);
    chk("reset_joy", 64'(joy), 64'h00);
    chk("reset_err_cnt", 64'(err_cnt), 64'd0);
    chk("reset_strobes", {62'd0, stb, ferr}, 64'd0);
    rst = 1'b0;
    a_hi = 8'h00;
    tick(5);
    chk("idle_kd_all_rows", 64'(kd), 64'h1F);

    // valid frame: JOY=0x10, row0 has key 0 down
    for (int r = 0; r < 8; r++) rows[r] = 5'h1F;
    rows[0] = 5'b11110;
    a_hi = 8'hFE;
    send_frame(8'h10, rows, FB, 5);
    wait_drain();
    chk("valid_kd", 64'(kd), 64'h1E);
    chk("valid_joy", 64'(joy), JOY_ON ? 64'h10 : 64'h00);

    // half-row merge
    rows[7] = 5'b11011;
    send_frame(8'h10, rows, FB, 5);
    wait_drain();
    a_hi = 8'h00; tick(1);
    chk("merge_all", 64'(kd), 64'h1A);
    a_hi = 8'h7F; tick(1);
    chk("merge_row7", 64'(kd), 64'h1B);
    a_hi = 8'hFF; tick(1);
    chk("merge_none", 64'(kd), 64'h1F);

    // short and overlong frames are rejected and leave state alone
    a_hi = 8'h00;
    rand_rows(rows);
    send_frame(8'hA5, rows, FB - 1, 5);
    wait_drain();
    chk("short_err_cnt", 64'(err_cnt), 64'd1);
    chk("short_kd_hold", 64'(kd), 64'h1A);
    send_frame(8'h5A, rows, FB + 1, 5);
    wait_drain();
    chk("long_err_cnt", 64'(err_cnt), 64'd2);
    chk("long_joy_hold", 64'(joy), JOY_ON ? 64'h10 : 64'h00);

    // saturation, mixed with back-to-back frames
    for (int i = 0; i < 20; i++) begin
      rand_rows(rows);
      n = ($urandom_range(0, 1) != 0) ? $urandom_range(1, FB - 1) : $urandom_range(FB + 1, FB + 4);
      send_frame(8'($urandom), rows, n, $urandom_range(1, 6));
    end
    wait_drain();
    chk("sat_err_cnt", 64'(err_cnt), 64'(ERR_MAX));
    rand_rows(rows);
    send_frame(8'($urandom), rows, FB, 5);
    wait_drain();
    chk("sat_after_valid", 64'(err_cnt), 64'(ERR_MAX));

    // reset in the middle of a frame, CS released afterwards
    cs = 1'b0;
    for (int i = 0; i < 20; i++) clock_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    tick(3);
    model_reset();
    rst = 1'b0;
    tick(5);
    cs = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (stb || ferr) seen++;
    end
    chk("no_strobe_after_reset", 64'(seen), 64'd0);
    chk("reset_mid_err_cnt", 64'(err_cnt), 64'd0);
    a_hi = 8'h00; tick(1);
    chk("reset_mid_kd", 64'(kd), 64'h1F);
    rand_rows(rows);
    send_frame(8'h3C, rows, FB, 5);
    wait_drain();

    // random traffic
    for (int i = 0; i < 30; i++) begin
      a_hi = 8'($urandom);
      rand_rows(rows);
      n = ($urandom_range(0, 2) != 0) ? FB : $urandom_range(1, FB + 3);
      send_frame(8'($urandom), rows, n, $urandom_range(1, 6));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
